// File: rtl/sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl
//
// Successive-approximation controller for the tile's analog comparator. It
// samples the input on the track/hold, then tests one DAC bit per trial (MSB
// first), keeping each bit the comparator says is at or below the held input.
// The finished code is published on result with a one-cycle done pulse.
//
// Ports
//   clk       tile clock (single domain)
//   rst_n     asynchronous active-low reset
//   ena       block enable; low aborts a conversion in progress
//   start     conversion request, honoured only while idle
//   cmp_in    comparator decision (async): 1 = held input >= DAC level
//   sample    track/hold control, 1 = track
//   dac_code  trial code driven to the capacitive DAC
//   busy      high from the first sample cycle through the done cycle
//   done      one-cycle completion pulse, result valid in the same cycle
//   result    last completed conversion, held until the next completion
// -----------------------------------------------------------------------------
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // One trial = DAC settling plus the two synchronizer stages, so the
    // decision sampled on the last cycle reflects the current trial code.
    localparam int TRIAL_CYCLES = SETTLE_CYCLES + 2;
    localparam int IDX_W        = $clog2(WIDTH);
    localparam int SET_W        = $clog2(TRIAL_CYCLES);
    localparam int SMP_W        = $clog2(SAMPLE_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(TRIAL_CYCLES - 1);
    localparam logic [SMP_W-1:0] SMP_LOAD = SMP_W'(SAMPLE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_TRIAL  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state_reg,  state_next;
    logic [WIDTH-1:0] acc_reg,    acc_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [IDX_W-1:0] idx_reg,    idx_next;
    logic [SET_W-1:0] settle_reg, settle_next;
    logic [SMP_W-1:0] smp_reg,    smp_next;
    logic             cmp_meta_reg;
    logic             cmp_s_reg;

    logic [WIDTH-1:0] trial_mask;    // one-hot bit under test, zero outside TRIAL
    logic [WIDTH-1:0] acc_decided;   // acc with the bit under test replaced by cmp_s

    // -------------------------------------------------------------------------
    // Comparator synchronizer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta_reg <= 1'b0;
            cmp_s_reg    <= 1'b0;
        end else begin
            cmp_meta_reg <= cmp_in;
            cmp_s_reg    <= cmp_meta_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Per-bit trial mask and decision
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign trial_mask[gi]  = (state_reg == ST_TRIAL) && (idx_reg == IDX_W'(gi));
            assign acc_decided[gi] = trial_mask[gi] ? cmp_s_reg : acc_reg[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        idx_next    = idx_reg;
        settle_next = settle_reg;
        smp_next    = smp_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start && ena) begin
                    state_next = ST_SAMPLE;
                    acc_next   = '0;
                    smp_next   = SMP_LOAD;
                end
            end
            ST_SAMPLE: begin
                if (smp_reg == '0) begin
                    state_next  = ST_TRIAL;
                    idx_next    = IDX_MSB;
                    settle_next = '0;
                end else begin
                    smp_next = smp_reg - SMP_W'(1);
                end
            end
            ST_TRIAL: begin
                if (settle_reg == SET_LAST) begin
                    acc_next    = acc_decided;
                    settle_next = '0;
                    if (idx_reg == '0) begin
                        state_next  = ST_DONE;
                        result_next = acc_decided;
                    end else begin
                        idx_next = idx_reg - IDX_W'(1);
                    end
                end else begin
                    settle_next = settle_reg + SET_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Disable overrides everything: drop straight to idle and leave the
        // previously published result untouched (no completion on abort).
        if (!ena && (state_reg != ST_IDLE)) begin
            state_next  = ST_IDLE;
            result_next = result_reg;
            settle_next = '0;
            smp_next    = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            result_reg <= '0;
            idx_reg    <= '0;
            settle_reg <= '0;
            smp_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
            idx_reg    <= idx_next;
            settle_reg <= settle_next;
            smp_reg    <= smp_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs decode directly from the state so an asynchronous reset clears
    // them without waiting for a clock edge.
    // -------------------------------------------------------------------------
    always_comb begin
        sample   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        dac_code = '0;
        case (state_reg)
            ST_SAMPLE: begin
                sample = 1'b1;
                busy   = 1'b1;
            end
            ST_TRIAL: begin
                busy     = 1'b1;
                dac_code = acc_reg | trial_mask;
            end
            ST_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                dac_code = acc_reg;
            end
            default: begin
                sample   = 1'b0;
            end
        endcase
    end

    assign result = result_reg;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_adc_ctrl
//
// Directed plus randomized bench for sar_adc_ctrl at default parameters.
// The comparator is modelled as cmp_in = (vin >= dac_code). Expected trial
// codes come from the closed form "top j bits of vin, then a 1 at bit 7-j";
// an ideal SAR resolves to vin itself.
// -----------------------------------------------------------------------------
module tb_sar_adc_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic         cmp_in;
    logic         sample;
    logic [W-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    logic [7:0]   vin;
    logic         cmp_force_en;
    logic         cmp_force_val;

    int checks   = 0;
    int failures = 0;

    assign cmp_in = cmp_force_en ? cmp_force_val : (vin >= dac_code);

    sar_adc_ctrl #(
        .WIDTH        (8),
        .SAMPLE_CYCLES(4),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (start),
        .cmp_in  (cmp_in),
        .sample  (sample),
        .dac_code(dac_code),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Trial j (0 = MSB) tests the known top j bits of vin plus bit 7-j.
    function automatic logic [7:0] trial_code(input logic [7:0] v, input int j);
        int prefix;
        prefix = (int'(v) >> (8 - j)) << (8 - j);
        return 8'(prefix | (1 << (7 - j)));
    endfunction

    // Expected outputs in cycle n (1-based) after the accepting start edge:
    // 4 sample cycles, 8 trials of 4 cycles, then the done cycle at n = 37.
    task automatic check_cycle(input int n, input logic [7:0] v);
        logic [7:0] exp_dac;
        if (n <= 4)       exp_dac = 8'h00;
        else if (n <= 36) exp_dac = trial_code(v, (n - 5) / 4);
        else              exp_dac = v;
        check($sformatf("sample@%0d", n), {31'b0, sample}, {31'b0, (n <= 4)});
        check($sformatf("busy@%0d", n),   {31'b0, busy},   32'd1);
        check($sformatf("done@%0d", n),   {31'b0, done},   {31'b0, (n == 37)});
        check($sformatf("dac@%0d", n),    {24'b0, dac_code}, {24'b0, exp_dac});
        if (n == 37)
            check("result_at_done", {24'b0, result}, {24'b0, v});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sample"}, {31'b0, sample},   32'd0);
        check({tag, "_busy"},   {31'b0, busy},     32'd0);
        check({tag, "_done"},   {31'b0, done},     32'd0);
        check({tag, "_dac"},    {24'b0, dac_code}, 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // idle cycle that follows done.
    task automatic convert(input logic [7:0] v, input int mid_start);
        int done_n;
        int ndone;
        vin    = v;
        start  = 1'b1;
        done_n = 0;
        ndone  = 0;
        for (int n = 1; n <= 38; n++) begin
            @(negedge clk);
            if (n <= 37) check_cycle(n, v);
            else         check_idle("idle_after_done");
            if (done === 1'b1) begin
                ndone++;
                if (done_n == 0) done_n = n;
            end
            if (n == 1) start = 1'b0;
            if (mid_start != 0 && n == mid_start)     start = 1'b1;
            if (mid_start != 0 && n == mid_start + 1) start = 1'b0;
        end
        check("done_count", ndone, 1);
        check("done_cycle", done_n, 37);
        $display("conv vin=%02h result=%02h done_cycle=%0d mid_start=%0d", v, result, done_n, mid_start);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int d1, d2, nd;
        rst_n         = 1'b0;
        ena           = 1'b1;
        start         = 1'b1;
        vin           = 8'h00;
        cmp_force_en  = 1'b1;
        cmp_force_val = 1'b0;

        // Reset held with start high and the comparator toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmp_force_val = ~cmp_force_val;
            check_idle("reset");
            check("reset_result", {24'b0, result}, 32'd0);
        end
        $display("reset held 6 cycles busy=%0b result=%02h", busy, result);

        // Release and request on the same negedge: the first edge accepts.
        @(negedge clk);
        cmp_force_en = 1'b0;
        rst_n        = 1'b1;

        // Nominal, rails, and an ignored mid-conversion start.
        convert(8'hA5, 0);
        convert(8'h00, 0);
        convert(8'hFF, 0);
        convert(8'h6B, 10);

        // start held high: back-to-back conversions, one idle cycle between.
        vin = 8'h3C;
        start = 1'b1;
        d1 = 0; d2 = 0; nd = 0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (n <= 37)      check_cycle(n, 8'h3C);
            else if (n == 38) check_idle("b2b_gap");
            else if (n <= 75) check_cycle(n - 38, 8'h3C);
            else              check_idle("b2b_end");
            if (done === 1'b1) begin
                nd++;
                if (nd == 1) d1 = n;
                if (nd == 2) d2 = n;
            end
            if (n == 40) start = 1'b0;
        end
        check("b2b_done_count", nd, 2);
        check("b2b_first_done", d1, 37);
        check("b2b_spacing", d2 - d1, 38);
        $display("b2b vin=3c dones=%0d first=%0d spacing=%0d result=%02h", nd, d1, d2 - d1, result);

        // Abort: complete 0x5A, then start 0x11 and drop ena in cycle 15.
        convert(8'h5A, 0);
        vin   = 8'h11;
        start = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            check_cycle(n, 8'h11);
            if (n == 1) start = 1'b0;
        end
        ena = 1'b0;
        for (int n = 16; n <= 25; n++) begin
            @(negedge clk);
            check_idle("abort");
            check("abort_result", {24'b0, result}, 32'h5A);
        end
        ena = 1'b1;
        $display("abort vin=11 busy=%0b dac=%02h result=%02h", busy, dac_code, result);

        // Asynchronous reset between edges during a trial.
        vin   = 8'hC3;
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            check_cycle(n, 8'hC3);
            if (n == 1) start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_result", {24'b0, result}, 32'd0);
        @(negedge clk);
        check_idle("async_rst_hold");
        $display("async reset mid-trial busy=%0b dac=%02h result=%02h", busy, dac_code, result);
        rst_n = 1'b1;
        convert(8'h77, 0);

        // Randomized inputs.
        for (int i = 0; i < 6; i++)
            convert(8'($urandom_range(0, 255)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
